tile_csr_gpio_bridge: RTL and testbench
=======================================

# tile_csr_gpio_bridge

Parametrised second-generation harness bridge for the 8-bit uC tile. It sits between the harness-side tile signals (CSR, data registers, GPIO pads) and the uC core. It adds three things: a CMD_DEPTH-deep command FIFO with level-triggered CSR capture, a registered response path, and synchronised GPIO inputs with sticky edge flags. Everything is gated by a registered harness/tile enable.

## Interface
Parameters:
- CSR_IN_WIDTH, 16, harness CSR input width; MSB is the GO bit.
- CSR_OUT_WIDTH, 16, harness CSR output width.
- REG_WIDTH, 32, data register width.
- GPIOS_NUM, 35, pad count.
- GPIO_IN_W, 8, synchronised input pads, taken from gpios_in[GPIO_IN_W-1:0].
- GPIO_OUT_W, 16, driven output pads, placed on gpios_out[GPIO_OUT_W-1:0].
- CMD_DEPTH, 4, FIFO entries; power of two, ≥2.
- SYNC_STAGES, 2, input synchroniser depth; ≥2.

Ports:
- clk in 1: the single clock.
- rst in 1: synchronous, active-high reset.
- harness_en, tile_en in 1 each: enables.
- csr_in in CSR_IN_WIDTH; csr_in_re out 1: capture acknowledge pulse.
- data_reg_a, data_reg_b in REG_WIDTH each.
- csr_out out CSR_OUT_WIDTH; csr_out_we out 1; data_reg_c out REG_WIDTH.
- gpios_in in GPIOS_NUM; gpios_out out GPIOS_NUM.
- active out 1: registered enable.
- cmd_valid out 1; cmd_ready in 1.
- cmd_code out CSR_IN_WIDTH-1; cmd_op_a, cmd_op_b out REG_WIDTH each.
- cmd_count out clog2(CMD_DEPTH)+1.
- rsp_valid in 1; rsp_ready out 1.
- rsp_status in CSR_OUT_WIDTH; rsp_data in REG_WIDTH.
- core_gpio_in out GPIO_IN_W; core_gpio_out in GPIO_OUT_W.
- gpio_edge out GPIO_IN_W; gpio_edge_clr in GPIO_IN_W.

## Operation
- **Enable:** active <= harness_en & tile_en, one cycle later. While active=0:
  - FIFO is flushed and cmd_count=0.
  - armed=0.
  - rsp_ready=0.
  - Sync flops, core_gpio_in and gpio_edge are held at 0.
  - gpios_out=0.
  - csr_out and data_reg_c hold their last values.
- **Capture arming:** armed sets when active=1 and csr_in[MSB]=0.
- **Push condition:** active & armed & csr_in[MSB] & count<CMD_DEPTH. On a push:
  - The entry {csr_in[MSB-1:0], data_reg_a, data_reg_b} is written, sampled in that cycle.
  - armed clears.
  - csr_in_re=1 for exactly that one cycle.
- **GO while full:** the command waits with armed still set. The push happens in the first cycle with space; data is sampled then.
- **GO held high:** yields exactly one push. The harness must drop GO to re-arm.
- **Pop:** when cmd_valid & cmd_ready. cmd_valid = (count≠0). cmd_code/op_a/op_b show the head entry and are stable while cmd_valid & !cmd_ready.
- **Full boundary:** full is judged on the pre-pop count. A pop in the same cycle does not enable a push.
- **Empty boundary:** there is no fall-through; cmd_valid=0, so pop is impossible.
- **Pointer wrap:** pointers wrap modulo CMD_DEPTH.
- **Response path:** rsp_ready = active. On rsp_valid & rsp_ready:
  - csr_out <= rsp_status and data_reg_c <= rsp_data.
  - csr_out_we=1 for one cycle.
  - Back-to-back responses give back-to-back pulses.
- **GPIO input:** gpios_in[GPIO_IN_W-1:0] passes through SYNC_STAGES flops to core_gpio_in.
  - gpio_edge[i] sets when the last two sync stages differ.
  - gpio_edge[i] clears on gpio_edge_clr[i]; set wins if both occur in the same cycle.
- **GPIO output:** gpios_out <= {zeros, core_gpio_out}, registered. Pads GPIO_OUT_W..GPIOS_NUM-1 are 0.
- **Pad overlap:** GPIO_IN_W and GPIO_OUT_W pads overlap in index; the integrator reserves distinct pads per direction. Unused pads are ignored.

## Timing
- **Reset values:** every output is 0 after rst, including csr_out, data_reg_c, gpios_out, cmd_*, cmd_count, gpio_edge, active, csr_in_re and csr_out_we. armed=0.
- **Reset precedence:** rst is synchronous and overrides all activity, including a push or response in the same cycle.
- **Enable latency:**
  - Enables high at cycle N → active=1 at N+1.
  - armed can set at N+1, with GO=0 sampled at N+1.
  - Earliest push is N+2.
- **Command latency:** push at cycle P (csr_in_re high at P) → cmd_valid and cmd_count=1 at P+1.
- **Simultaneous push and pop:** cmd_count is unchanged.
- **Response latency:** handshake at R → csr_out, data_reg_c and csr_out_we valid at R+1.
- **GPIO latency:** pad change at T → core_gpio_in at T+SYNC_STAGES → gpio_edge at T+SYNC_STAGES+1.
- **Output latency:** core_gpio_out → gpios_out in 1 cycle.
- **Enable drop mid-operation:** active falls at D+1. In that same cycle the FIFO empties and gpios_out becomes 0. An accepted response at D still updates csr_out at D+1.

## Test plan
- **Reset and enable:** rst, then enables=1 with GO=0 → active at +1. Then GO=1, csr_in=0x8005, a=0x11, b=0x22 → one csr_in_re pulse. Next cycle: cmd_code=0x0005, op_a=0x11, op_b=0x22, cmd_count=1.
- **GO held and full FIFO:**
  - Hold GO high for 10 cycles → exactly one push.
  - Toggle GO 5 times with cmd_ready=0, CMD_DEPTH=4 → 4 pushes and cmd_count=4. The 5th csr_in_re comes only in the cycle after the first pop.
- **Ordering and wrap:** stream 9 commands 0x8001..0x8009 with random cmd_ready → popped in order 1..9 with no loss or duplicate.
- **Response path:** rsp_valid for 2 consecutive cycles with status 0x00A1/0x00A2, data 0xDEAD0001/0xDEAD0002 → two consecutive csr_out_we pulses with matching csr_out and data_reg_c.
- **GPIO:** with SYNC_STAGES=2, drive gpios_in[3] 0→1 at T → core_gpio_in[3]=1 at T+2 and gpio_edge[3]=1 at T+3. Assert gpio_edge_clr[3] in the same cycle as a new edge → the flag stays 1.
- **Enable drop:** drop tile_en with 3 queued commands → at +1, active=0, cmd_valid=0, cmd_count=0, gpios_out=0. After re-enable, GO must be seen low before the next capture.

Source files
------------

// File: rtl/tile_csr_gpio_bridge.sv
// Harness-to-uC bridge: GO-captured command FIFO, registered response path, synchronised GPIO with sticky edges.
// Latency: push->cmd_valid 1 cycle, rsp->csr_out 1, pad->core_gpio_in SYNC_STAGES; command push stalls (armed) while full.

module tile_csr_gpio_bridge_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push_vld,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop_vld,
  output logic [W-1:0]             head_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Pointers are exactly AW bits, so DEPTH being a power of two gives the wrap for free.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + 1'b1;
      if (pop_vld)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push_vld} - {{AW{1'b0}}, pop_vld};
    end
  end

  always_ff @(posedge clk) begin
    if (push_vld) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
endmodule

module tile_csr_gpio_bridge #(
  parameter int CSR_IN_WIDTH  = 16,
  parameter int CSR_OUT_WIDTH = 16,
  parameter int REG_WIDTH     = 32,
  parameter int GPIOS_NUM     = 35,
  parameter int GPIO_IN_W     = 8,
  parameter int GPIO_OUT_W    = 16,
  parameter int CMD_DEPTH     = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       harness_en,
  input  logic                       tile_en,
  input  logic [CSR_IN_WIDTH-1:0]    csr_in,
  output logic                       csr_in_re,
  input  logic [REG_WIDTH-1:0]       data_reg_a,
  input  logic [REG_WIDTH-1:0]       data_reg_b,
  output logic [CSR_OUT_WIDTH-1:0]   csr_out,
  output logic                       csr_out_we,
  output logic [REG_WIDTH-1:0]       data_reg_c,
  input  logic [GPIOS_NUM-1:0]       gpios_in,
  output logic [GPIOS_NUM-1:0]       gpios_out,
  output logic                       active,
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  output logic [CSR_IN_WIDTH-2:0]    cmd_code,
  output logic [REG_WIDTH-1:0]       cmd_op_a,
  output logic [REG_WIDTH-1:0]       cmd_op_b,
  output logic [$clog2(CMD_DEPTH):0] cmd_count,
  input  logic                       rsp_valid,
  output logic                       rsp_ready,
  input  logic [CSR_OUT_WIDTH-1:0]   rsp_status,
  input  logic [REG_WIDTH-1:0]       rsp_data,
  output logic [GPIO_IN_W-1:0]       core_gpio_in,
  input  logic [GPIO_OUT_W-1:0]      core_gpio_out,
  output logic [GPIO_IN_W-1:0]       gpio_edge,
  input  logic [GPIO_IN_W-1:0]       gpio_edge_clr
);
  localparam int CNT_W = $clog2(CMD_DEPTH) + 1;

  typedef struct packed {
    logic [CSR_IN_WIDTH-2:0] code;
    logic [REG_WIDTH-1:0]    op_a;
    logic [REG_WIDTH-1:0]    op_b;
  } cmd_t;

  logic                 en_next;
  logic                 go;
  logic                 armed_q;
  logic                 fifo_full;
  logic                 push_vld;
  logic                 pop_vld;
  logic                 rsp_fire;
  cmd_t                 push_dat;
  cmd_t                 head_dat;
  logic [GPIOS_NUM-1:0] gpios_out_d;
  logic [GPIO_IN_W-1:0] sync_q [SYNC_STAGES];
  logic [GPIO_IN_W-1:0] hist_q;
  logic                 unused_pads;

  // Everything gated by "active" keys off the enable being sampled now, so it is clear the same cycle active falls.
  assign en_next   = harness_en & tile_en;
  assign go        = csr_in[CSR_IN_WIDTH-1];
  assign fifo_full = (cmd_count == CNT_W'(CMD_DEPTH));
  assign push_vld  = !rst && active && armed_q && go && !fifo_full;
  assign cmd_valid = (cmd_count != '0);
  assign pop_vld   = cmd_valid && cmd_ready;
  assign rsp_ready = active;
  assign rsp_fire  = rsp_valid && active;
  assign csr_in_re = push_vld;

  assign push_dat.code = csr_in[CSR_IN_WIDTH-2:0];
  assign push_dat.op_a = data_reg_a;
  assign push_dat.op_b = data_reg_b;

  tile_csr_gpio_bridge_fifo #(
    .W     ($bits(cmd_t)),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (!en_next),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_vld  (pop_vld),
    .head_dat (head_dat),
    .count    (cmd_count)
  );

  // Storage is not reset, so the head is masked until an entry is present.
  assign cmd_code = cmd_valid ? head_dat.code : '0;
  assign cmd_op_a = cmd_valid ? head_dat.op_a : '0;
  assign cmd_op_b = cmd_valid ? head_dat.op_b : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      active  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      active <= en_next;
      if (!en_next)              armed_q <= 1'b0;
      else if (push_vld)         armed_q <= 1'b0;
      else if (active && !go)    armed_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      csr_out    <= '0;
      data_reg_c <= '0;
      csr_out_we <= 1'b0;
    end else begin
      csr_out_we <= rsp_fire;
      if (rsp_fire) begin
        csr_out    <= rsp_status;
        data_reg_c <= rsp_data;
      end
    end
  end

  always_comb begin
    gpios_out_d                 = '0;
    gpios_out_d[GPIO_OUT_W-1:0] = core_gpio_out;
  end

  always_ff @(posedge clk) begin
    if (rst || !en_next) gpios_out <= '0;
    else                 gpios_out <= gpios_out_d;
  end

  // hist_q is the previous value of the last sync stage; a difference marks an edge one cycle after core_gpio_in moves.
  always_ff @(posedge clk) begin
    if (rst || !en_next) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      hist_q    <= '0;
      gpio_edge <= '0;
    end else begin
      sync_q[0] <= gpios_in[GPIO_IN_W-1:0];
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      hist_q    <= sync_q[SYNC_STAGES-1];
      gpio_edge <= (gpio_edge & ~gpio_edge_clr) | (sync_q[SYNC_STAGES-1] ^ hist_q);
    end
  end

  assign core_gpio_in = sync_q[SYNC_STAGES-1];
  assign unused_pads  = ^gpios_in[GPIOS_NUM-1:GPIO_IN_W];
endmodule

// File: tb/tb_tile_csr_gpio_bridge.sv
// Directed + randomized bench for tile_csr_gpio_bridge against a queue-based cycle model.
module tb_tile_csr_gpio_bridge;
  localparam int DEPTH = 4;
  localparam int S     = 2;

  logic        clk;
  logic        rst;
  logic        harness_en, tile_en;
  logic [15:0] csr_in;
  logic        csr_in_re;
  logic [31:0] data_reg_a, data_reg_b;
  logic [15:0] csr_out;
  logic        csr_out_we;
  logic [31:0] data_reg_c;
  logic [34:0] gpios_in, gpios_out;
  logic        active;
  logic        cmd_valid, cmd_ready;
  logic [14:0] cmd_code;
  logic [31:0] cmd_op_a, cmd_op_b;
  logic [2:0]  cmd_count;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_status;
  logic [31:0] rsp_data;
  logic [7:0]  core_gpio_in;
  logic [15:0] core_gpio_out;
  logic [7:0]  gpio_edge, gpio_edge_clr;

  tile_csr_gpio_bridge #(
    .CSR_IN_WIDTH(16), .CSR_OUT_WIDTH(16), .REG_WIDTH(32), .GPIOS_NUM(35),
    .GPIO_IN_W(8), .GPIO_OUT_W(16), .CMD_DEPTH(DEPTH), .SYNC_STAGES(S)
  ) dut (
    .clk(clk), .rst(rst), .harness_en(harness_en), .tile_en(tile_en),
    .csr_in(csr_in), .csr_in_re(csr_in_re), .data_reg_a(data_reg_a), .data_reg_b(data_reg_b),
    .csr_out(csr_out), .csr_out_we(csr_out_we), .data_reg_c(data_reg_c),
    .gpios_in(gpios_in), .gpios_out(gpios_out), .active(active),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code),
    .cmd_op_a(cmd_op_a), .cmd_op_b(cmd_op_b), .cmd_count(cmd_count),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status), .rsp_data(rsp_data),
    .core_gpio_in(core_gpio_in), .core_gpio_out(core_gpio_out),
    .gpio_edge(gpio_edge), .gpio_edge_clr(gpio_edge_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int re_pulses = 0;
  bit last_re = 0;
  logic [14:0] popped[$];

  // Reference model: command queue, armed flag, response registers, pad delay line.
  typedef logic [78:0] ent_t;
  ent_t        q[$];
  bit          m_active, m_armed, m_we;
  logic [15:0] m_csr_out;
  logic [31:0] m_dc;
  logic [34:0] m_gpios_out;
  logic [7:0]  dl [S];
  logic [7:0]  m_prev, m_edge;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_active = 0; m_armed = 0; m_we = 0;
    m_csr_out = '0; m_dc = '0; m_gpios_out = '0;
    for (int i = 0; i < S; i++) dl[i] = '0;
    m_prev = '0; m_edge = '0;
  endtask

  task automatic model_step();
    bit en, go, push, pop;
    logic [7:0] set;
    en   = harness_en && tile_en;
    go   = csr_in[15];
    push = m_active && m_armed && go && (q.size() < DEPTH);
    pop  = (q.size() != 0) && cmd_ready;
    if (rst) begin
      model_reset();
    end else begin
      m_we = rsp_valid && m_active;
      if (m_we) begin m_csr_out = rsp_status; m_dc = rsp_data; end
      if (!en) begin
        q.delete();
        m_armed = 0;
        for (int i = 0; i < S; i++) dl[i] = '0;
        m_prev = '0; m_edge = '0;
        m_gpios_out = '0;
      end else begin
        if (pop) void'(q.pop_front());
        if (push) q.push_back({csr_in[14:0], data_reg_a, data_reg_b});
        if (push) m_armed = 0;
        else if (m_active && !go) m_armed = 1;
        set    = dl[S-1] ^ m_prev;
        m_edge = (m_edge & ~gpio_edge_clr) | set;
        m_prev = dl[S-1];
        for (int i = S-1; i > 0; i--) dl[i] = dl[i-1];
        dl[0] = gpios_in[7:0];
        m_gpios_out = {19'b0, core_gpio_out};
      end
      m_active = en;
    end
  endtask

  task automatic check_all();
    ent_t h;
    bit exp_re;
    h = (q.size() != 0) ? q[0] : '0;
    exp_re = !rst && m_active && m_armed && csr_in[15] && (q.size() < DEPTH);
    chk("active", active, m_active);
    chk("rsp_ready", rsp_ready, m_active);
    chk("csr_in_re", csr_in_re, exp_re);
    chk("cmd_valid", cmd_valid, q.size() != 0);
    chk("cmd_count", cmd_count, q.size());
    chk("cmd_code", cmd_code, h[78:64]);
    chk("cmd_op_a", cmd_op_a, h[63:32]);
    chk("cmd_op_b", cmd_op_b, h[31:0]);
    chk("csr_out", csr_out, m_csr_out);
    chk("data_reg_c", data_reg_c, m_dc);
    chk("csr_out_we", csr_out_we, m_we);
    chk("gpios_out", gpios_out, m_gpios_out);
    chk("core_gpio_in", core_gpio_in, dl[S-1]);
    chk("gpio_edge", gpio_edge, m_edge);
  endtask

  // Inputs are set by the caller at posedge+1; returns at the next posedge+1.
  task automatic cycle();
    #1;
    check_all();
    last_re = (csr_in_re === 1'b1);
    if (last_re) re_pulses++;
    if (!rst && cmd_valid === 1'b1 && cmd_ready) popped.push_back(cmd_code);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_cmd(input logic [14:0] code);
    csr_in = {1'b0, code}; cycle();
    csr_in = {1'b1, code}; data_reg_a = $urandom; data_reg_b = $urandom; cycle();
  endtask

  initial begin
    int r0;
    bit got;
    rst = 1; harness_en = 0; tile_en = 0; csr_in = '0; data_reg_a = '0; data_reg_b = '0;
    cmd_ready = 0; rsp_valid = 0; rsp_status = '0; rsp_data = '0;
    gpios_in = '0; core_gpio_out = '0; gpio_edge_clr = '0;
    @(posedge clk); #1;
    model_reset();
    cycle(); cycle();
    rst = 0;

    // Enable, arm, first capture.
    harness_en = 1; tile_en = 1; csr_in = 16'h0000;
    cycle();
    chk("en_active_n1", active, 1);
    cycle();
    csr_in = 16'h8005; data_reg_a = 32'h11; data_reg_b = 32'h22;
    cycle();
    chk("first_re_count", re_pulses, 1);
    chk("first_code", cmd_code, 15'h0005);
    chk("first_op_a", cmd_op_a, 32'h11);
    chk("first_op_b", cmd_op_b, 32'h22);
    chk("first_count", cmd_count, 1);

    // GO held high yields a single push.
    r0 = re_pulses;
    repeat (10) cycle();
    chk("go_held_one_push", re_pulses - r0, 0);
    csr_in = 16'h0000; cmd_ready = 1; cycle(); cycle();
    cmd_ready = 0;
    csr_in = 16'h8077; r0 = re_pulses;
    repeat (10) cycle();
    chk("go_held_10_one_push", re_pulses - r0, 1);
    csr_in = 16'h0000; cmd_ready = 1; repeat (3) cycle();
    cmd_ready = 0;

    // Fill to full; the fifth GO waits for space.
    r0 = re_pulses;
    for (int i = 0; i < 5; i++) go_cmd(15'(16'h40 + i));
    chk("full_pushes", re_pulses - r0, 4);
    chk("full_count", cmd_count, 4);
    r0 = re_pulses;
    cmd_ready = 1; cycle();
    chk("full_no_push_on_pop", re_pulses - r0, 0);
    cmd_ready = 0; cycle();
    chk("full_push_after_pop", re_pulses - r0, 1);
    chk("full_count_after", cmd_count, 4);
    csr_in = 16'h0000; cmd_ready = 1; repeat (6) cycle();

    // Ordering and pointer wrap with random cmd_ready.
    popped.delete();
    for (int k = 1; k <= 9; k++) begin
      csr_in = 16'(k); cmd_ready = 1'($urandom_range(0, 1)); cycle();
      csr_in = 16'h8000 | 16'(k); data_reg_a = $urandom; data_reg_b = $urandom;
      got = 0;
      for (int t = 0; t < 40 && !got; t++) begin
        cmd_ready = 1'($urandom_range(0, 1));
        cycle();
        got = last_re;
      end
      chk("wrap_push_in_time", got, 1);
    end
    csr_in = 16'h0000; cmd_ready = 1; repeat (6) cycle();
    chk("wrap_pop_count", popped.size(), 9);
    for (int i = 0; i < 9 && i < popped.size(); i++) chk("wrap_order", popped[i], 15'(i + 1));
    cmd_ready = 0;

    // Back-to-back responses.
    rsp_valid = 1; rsp_status = 16'h00A1; rsp_data = 32'hDEAD0001; cycle();
    chk("rsp1_we", csr_out_we, 1);
    chk("rsp1_status", csr_out, 16'h00A1);
    chk("rsp1_data", data_reg_c, 32'hDEAD0001);
    rsp_status = 16'h00A2; rsp_data = 32'hDEAD0002; cycle();
    chk("rsp2_we", csr_out_we, 1);
    chk("rsp2_status", csr_out, 16'h00A2);
    chk("rsp2_data", data_reg_c, 32'hDEAD0002);
    rsp_valid = 0; cycle();
    chk("rsp_we_drop", csr_out_we, 0);
    chk("rsp_hold", csr_out, 16'h00A2);
    for (int i = 0; i < 8; i++) begin
      rsp_valid = 1'($urandom_range(0, 1)); rsp_status = 16'($urandom); rsp_data = $urandom;
      cycle();
    end
    rsp_valid = 0;

    // GPIO sync latency, edge flag and set-beats-clear.
    gpios_in = '0; gpio_edge_clr = 8'hFF; core_gpio_out = 16'hBEEF;
    repeat (4) cycle();
    gpio_edge_clr = '0;
    chk("gpios_out_val", gpios_out, 35'h0BEEF);
    gpios_in[3] = 1'b1; cycle();
    chk("gpio_core_t1", core_gpio_in[3], 0);
    cycle();
    chk("gpio_core_t2", core_gpio_in[3], 1);
    chk("gpio_edge_t2", gpio_edge[3], 0);
    cycle();
    chk("gpio_edge_t3", gpio_edge[3], 1);
    gpio_edge_clr = 8'h08; cycle();
    chk("gpio_edge_cleared", gpio_edge[3], 0);
    gpio_edge_clr = '0;
    gpios_in[3] = 1'b0; cycle(); cycle();
    gpio_edge_clr = 8'h08; cycle();
    chk("gpio_set_wins", gpio_edge[3], 1);
    gpio_edge_clr = '0;
    for (int i = 0; i < 20; i++) begin
      gpios_in = {3'($urandom), $urandom};
      gpio_edge_clr = 8'($urandom) & 8'($urandom);
      core_gpio_out = 16'($urandom);
      cycle();
    end
    gpio_edge_clr = '0;

    // Enable drop with queued commands and a response in flight.
    cmd_ready = 0;
    for (int i = 0; i < 3; i++) go_cmd(15'(16'h60 + i));
    csr_in = 16'h0000; core_gpio_out = 16'hA5A5; cycle();
    chk("drop_pre_count", cmd_count, 3);
    tile_en = 0; rsp_valid = 1; rsp_status = 16'h00B7; rsp_data = 32'h0BADF00D; cycle();
    rsp_valid = 0;
    chk("drop_active", active, 0);
    chk("drop_cmd_valid", cmd_valid, 0);
    chk("drop_count", cmd_count, 0);
    chk("drop_gpios_out", gpios_out, 0);
    chk("drop_rsp_taken", csr_out, 16'h00B7);
    csr_in = 16'h8033; cycle();
    tile_en = 1; r0 = re_pulses;
    repeat (4) cycle();
    chk("reen_no_capture", re_pulses - r0, 0);
    csr_in = 16'h0033; cycle();
    csr_in = 16'h8033; cycle();
    chk("reen_capture", re_pulses - r0, 1);

    // Reset overrides a pending push and response.
    csr_in = 16'h0034; cycle();
    csr_in = 16'h8034; rsp_valid = 1; rsp_status = 16'h1234; rst = 1; cycle();
    rst = 0; rsp_valid = 0; csr_in = 16'h0000;
    chk("rst_count", cmd_count, 0);
    chk("rst_csr_out", csr_out, 0);
    chk("rst_we", csr_out_we, 0);
    chk("rst_active", active, 0);

    // Random soak against the model.
    for (int i = 0; i < 300; i++) begin
      tile_en = ($urandom_range(0, 19) != 0);
      csr_in = 16'($urandom);
      data_reg_a = $urandom; data_reg_b = $urandom;
      cmd_ready = 1'($urandom_range(0, 1));
      rsp_valid = 1'($urandom_range(0, 1)); rsp_status = 16'($urandom); rsp_data = $urandom;
      gpios_in = {3'($urandom), $urandom};
      gpio_edge_clr = 8'($urandom);
      core_gpio_out = 16'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
